// File: rtl/wb_master_sequencer.sv
// Wishbone classic master, one bus cycle outstanding; optional ACK timeout (WBM_TIMEOUT_EN).
// Latency: STB rises the cycle after the command handshake; response pulse the cycle after ACK.
// Backpressure: CMD_READY_O only in IDLE; responses have no backpressure (one-cycle pulse).
module wb_master_sequencer #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CMD_VALID_I,
    output logic              CMD_READY_O,
    input  logic              CMD_WE_I,
    input  logic [ADDR_W-1:0] CMD_ADR_I,
    input  logic [DATA_W-1:0] CMD_DAT_I,
    output logic              RSP_VALID_O,
    output logic [DATA_W-1:0] RSP_DAT_O,
    output logic              RSP_ERR_O,
    output logic              BUSY_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [DATA_W-1:0] DAT_O,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic              ACK_I
);

    // Out-of-range parameters stop elaboration rather than building a broken gap/timeout.
    generate
        if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
            $error("wb_master_sequencer: GAP_CYCLES must be 1..15 and TIMEOUT_CYCLES 2..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                ack_hit;
    logic                expire;
    logic                bus_act;
    logic                we_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic                rsp_vld_q;
    logic [DATA_W-1:0]   rsp_dat_q;
    logic [3:0]          gap_cnt;

`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
    logic        rsp_err_q;
`endif

    // State register; reset forces IDLE.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and the per-cycle events that steer the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        expire    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (CMD_VALID_I) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ACK_I) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_GAP;
                end
`ifdef WBM_TIMEOUT_EN
                // A coincident ACK wins over expiry, so expiry is only checked without ACK.
                else if (to_cnt == TO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_GAP;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt <= 4'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus signalling, response register and gap counter.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            bus_act   <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            gap_cnt   <= '0;
        end else begin
            rsp_vld_q <= 1'b0;
            if (accept) begin
                we_q    <= CMD_WE_I;
                adr_q   <= CMD_ADR_I;
                dat_q   <= CMD_DAT_I;
                bus_act <= 1'b1;
            end else if (ack_hit) begin
                bus_act   <= 1'b0;
                we_q      <= 1'b0;
                rsp_dat_q <= we_q ? '0 : DAT_I;
                rsp_vld_q <= 1'b1;
                gap_cnt   <= GAP_LOAD;
            end else if (expire) begin
                bus_act   <= 1'b0;
                we_q      <= 1'b0;
                rsp_dat_q <= '0;
                rsp_vld_q <= 1'b1;
                gap_cnt   <= GAP_LOAD;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

`ifdef WBM_TIMEOUT_EN
    // ACK wait counter and error flag; the flag holds until the next response.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            to_cnt    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept)                           to_cnt <= '0;
            else if (state == ST_WAIT && !ACK_I)  to_cnt <= to_cnt + 16'd1;
            if (ack_hit)     rsp_err_q <= 1'b0;
            else if (expire) rsp_err_q <= 1'b1;
        end
    end
    assign RSP_ERR_O = rsp_err_q;
`else
    assign RSP_ERR_O = 1'b0;
`endif

    assign CMD_READY_O = RST_I && (state == ST_IDLE);
    assign BUSY_O      = (state != ST_IDLE);
    assign CYC_O       = bus_act;
    assign STB_O       = bus_act;
    assign WE_O        = we_q;
    assign ADR_O       = adr_q;
    assign DAT_O       = dat_q;
    assign RSP_VALID_O = rsp_vld_q;
    assign RSP_DAT_O   = rsp_dat_q;

endmodule

// File: tb/tb_wb_master_sequencer.sv
// Directed bench for wb_master_sequencer against a registered-ACK slave model.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Timeout scenarios are built when WBM_TIMEOUT_EN is defined; otherwise WAIT-forever is checked.
module tb_wb_master_sequencer;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        CMD_VALID_I = 1'b0;
    logic        CMD_READY_O;
    logic        CMD_WE_I = 1'b0;
    logic [15:0] CMD_ADR_I = '0;
    logic [31:0] CMD_DAT_I = '0;
    logic        RSP_VALID_O;
    logic [31:0] RSP_DAT_O;
    logic        RSP_ERR_O;
    logic        BUSY_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [15:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    int compared   = 0;
    int mismatched = 0;

    // Slave model: ACK registered one cycle after STB, re-armed by dropping ACK.
    logic        slave_en = 1'b1;
    logic        man_sel  = 1'b0;
    logic        man_ack  = 1'b0;
    logic [31:0] man_dat  = '0;
    logic        s_ack;
    logic [31:0] s_dat;
    logic [31:0] mem [16] = '{32'h0, 32'h0, 32'h0, 32'h0,
                              32'h1111_0004, 32'h2222_0005, 32'h3333_0006, 32'h4444_0007,
                              32'h0, 32'h0, 32'h0000_ABCD, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};

    assign ACK_I = s_ack | man_ack;
    assign DAT_I = man_sel ? man_dat : s_dat;

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        if (!RST_I)        s_ack <= 1'b0;
        else if (slave_en) s_ack <= CYC_O & STB_O & ~s_ack;
        else               s_ack <= 1'b0;
        if (CYC_O & STB_O) s_dat <= mem[ADR_O[3:0]];
        if (CYC_O & STB_O & WE_O & s_ack) mem[ADR_O[3:0]] <= DAT_O;
    end

    wb_master_sequencer #(
        .ADDR_W(16), .DATA_W(32), .GAP_CYCLES(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .CMD_VALID_I(CMD_VALID_I), .CMD_READY_O(CMD_READY_O),
        .CMD_WE_I(CMD_WE_I), .CMD_ADR_I(CMD_ADR_I), .CMD_DAT_I(CMD_DAT_I),
        .RSP_VALID_O(RSP_VALID_O), .RSP_DAT_O(RSP_DAT_O), .RSP_ERR_O(RSP_ERR_O),
        .BUSY_O(BUSY_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    // Issues one command and observes `win` samples, sample 0 right after the handshake edge.
    task automatic run_cmd(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                           input int win, output int stb_cnt, output int rsp_cnt,
                           output int rsp_idx, output logic [31:0] rdat, output logic rerr,
                           output logic [15:0] adr_seen, output logic we_seen,
                           output logic [31:0] dat_seen);
        int n = 0;
        CMD_VALID_I = 1'b1;
        CMD_WE_I    = we;
        CMD_ADR_I   = adr;
        CMD_DAT_I   = dat;
        while (!CMD_READY_O && n < 50) begin
            step();
            n++;
        end
        if (!CMD_READY_O) begin
            compared++;
            mismatched++;
            $display("FAIL ready_wait: CMD_READY_O never rose within 50 cycles");
        end
        step();
        CMD_VALID_I = 1'b0;
        stb_cnt  = 0;
        rsp_cnt  = 0;
        rsp_idx  = -1;
        rdat     = 32'hDEAD_DEAD;
        rerr     = 1'bx;
        adr_seen = ADR_O;
        we_seen  = WE_O;
        dat_seen = DAT_O;
        for (int i = 0; i < win; i++) begin
            if (i > 0) step();
            stb_cnt += int'(STB_O);
            if (RSP_VALID_O) begin
                rsp_cnt++;
                if (rsp_idx < 0) rsp_idx = i;
                rdat = RSP_DAT_O;
                rerr = RSP_ERR_O;
            end
        end
    endtask

    task automatic test_reset();
        RST_I = 1'b0;
        repeat (3) step();
        compared++; if (CYC_O !== 1'b0 || STB_O !== 1'b0) begin mismatched++; $display("FAIL reset_bus: cyc=%b stb=%b want 0 0", CYC_O, STB_O); end
        compared++; if (CMD_READY_O !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b want 0", CMD_READY_O); end
        compared++; if (BUSY_O !== 1'b0 || RSP_VALID_O !== 1'b0) begin mismatched++; $display("FAIL reset_busy_rsp: busy=%b rsp=%b want 0 0", BUSY_O, RSP_VALID_O); end
        compared++; if (ADR_O !== 16'h0 || DAT_O !== 32'h0 || WE_O !== 1'b0) begin mismatched++; $display("FAIL reset_regs: adr=%h dat=%h we=%b want 0", ADR_O, DAT_O, WE_O); end
        compared++; if (RSP_DAT_O !== 32'h0 || RSP_ERR_O !== 1'b0) begin mismatched++; $display("FAIL reset_rsp: dat=%h err=%b want 0 0", RSP_DAT_O, RSP_ERR_O); end
        RST_I = 1'b1;
        step();
        compared++; if (CMD_READY_O !== 1'b1) begin mismatched++; $display("FAIL ready_after_reset: got %b want 1", CMD_READY_O); end
    endtask

    task automatic test_read();
        int sc, rc, ri; logic [31:0] rd, ds; logic re, ws; logic [15:0] as;
        run_cmd(1'b0, 16'h400A, 32'h0, 8, sc, rc, ri, rd, re, as, ws, ds);
        compared++; if (as !== 16'h400A || ws !== 1'b0) begin mismatched++; $display("FAIL read_bus: adr=%h we=%b want 400a 0", as, ws); end
        compared++; if (sc !== 2) begin mismatched++; $display("FAIL read_stb_len: got %0d want 2", sc); end
        compared++; if (rc !== 1 || ri !== 2) begin mismatched++; $display("FAIL read_rsp_pulse: count=%0d idx=%0d want 1 2", rc, ri); end
        compared++; if (rd !== 32'h0000ABCD || re !== 1'b0) begin mismatched++; $display("FAIL read_data: dat=%h err=%b want 0000abcd 0", rd, re); end
    endtask

    task automatic test_write_read();
        int sc, rc, ri; logic [31:0] rd, ds; logic re, ws; logic [15:0] as;
        run_cmd(1'b1, 16'h0002, 32'h12345678, 8, sc, rc, ri, rd, re, as, ws, ds);
        compared++; if (ws !== 1'b1 || as !== 16'h0002 || ds !== 32'h12345678) begin mismatched++; $display("FAIL write_bus: we=%b adr=%h dat=%h want 1 0002 12345678", ws, as, ds); end
        compared++; if (rc !== 1 || rd !== 32'h0 || re !== 1'b0) begin mismatched++; $display("FAIL write_rsp: count=%0d dat=%h err=%b want 1 0 0", rc, rd, re); end
        run_cmd(1'b0, 16'h0002, 32'h0, 8, sc, rc, ri, rd, re, as, ws, ds);
        compared++; if (rc !== 1 || rd !== 32'h12345678) begin mismatched++; $display("FAIL readback: count=%0d dat=%h want 1 12345678", rc, rd); end
    endtask

    task automatic test_back_to_back();
        int issued = 0, viol = 0, run = 0, min_low = 99;
        logic hs, seen_high = 1'b0, prev_stb = 1'b0;
        int rsp_t[$];
        logic [31:0] rsp_d[$];
        logic [31:0] exp_d [4] = '{32'h1111_0004, 32'h2222_0005, 32'h3333_0006, 32'h4444_0007};
        CMD_VALID_I = 1'b1;
        CMD_WE_I    = 1'b0;
        CMD_ADR_I   = 16'h0004;
        for (int c = 0; c < 30; c++) begin
            hs = CMD_READY_O && CMD_VALID_I;
            step();
            if (hs) begin
                issued++;
                if (issued < 4) CMD_ADR_I = 16'(4 + issued);
                else            CMD_VALID_I = 1'b0;
            end
            if (RSP_VALID_O) begin rsp_t.push_back(c); rsp_d.push_back(RSP_DAT_O); end
            if (CMD_READY_O && BUSY_O) viol++;
            if (STB_O && !prev_stb && seen_high && run < min_low) min_low = run;
            if (STB_O) begin seen_high = 1'b1; run = 0; end
            else run++;
            prev_stb = STB_O;
        end
        CMD_VALID_I = 1'b0;
        compared++; if (issued !== 4) begin mismatched++; $display("FAIL b2b_issued: got %0d want 4", issued); end
        compared++; if (rsp_t.size() !== 4) begin mismatched++; $display("FAIL b2b_rsp_count: got %0d want 4", rsp_t.size()); end
        compared++; if (viol !== 0) begin mismatched++; $display("FAIL b2b_ready_busy: overlap cycles %0d want 0", viol); end
        compared++; if (min_low < 1 || min_low == 99) begin mismatched++; $display("FAIL b2b_stb_gap: min low run %0d want >=1", min_low); end
        if (rsp_t.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (rsp_t[i+1] - rsp_t[i] !== 4) begin mismatched++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, rsp_t[i+1] - rsp_t[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (rsp_d[i] !== exp_d[i]) begin mismatched++; $display("FAIL b2b_data%0d: got %h want %h", i, rsp_d[i], exp_d[i]); end
            end
        end
    endtask

`ifdef WBM_TIMEOUT_EN
    task automatic test_timeout();
        int sc, rc, ri; logic [31:0] rd, ds; logic re, ws; logic [15:0] as;
        slave_en = 1'b0;
        run_cmd(1'b0, 16'h400A, 32'h0, 24, sc, rc, ri, rd, re, as, ws, ds);
        compared++; if (sc !== 16) begin mismatched++; $display("FAIL timeout_stb_len: got %0d want 16", sc); end
        compared++; if (rc !== 1 || ri !== 16) begin mismatched++; $display("FAIL timeout_rsp: count=%0d idx=%0d want 1 16", rc, ri); end
        compared++; if (re !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL timeout_err: err=%b dat=%h want 1 0", re, rd); end
        slave_en = 1'b1;
        run_cmd(1'b0, 16'h400A, 32'h0, 8, sc, rc, ri, rd, re, as, ws, ds);
        compared++; if (rc !== 1 || rd !== 32'h0000ABCD || re !== 1'b0) begin mismatched++; $display("FAIL after_timeout: count=%0d dat=%h err=%b want 1 0000abcd 0", rc, rd, re); end
    endtask

    task automatic test_timeout_ack_race();
        int n = 0;
        slave_en = 1'b0;
        man_sel  = 1'b1;
        man_dat  = 32'h5A5A_0F0F;
        CMD_VALID_I = 1'b1; CMD_WE_I = 1'b0; CMD_ADR_I = 16'h0003;
        while (!CMD_READY_O && n < 50) begin step(); n++; end
        step();
        CMD_VALID_I = 1'b0;
        for (int i = 1; i <= 15; i++) step();
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        compared++; if (RSP_VALID_O !== 1'b1 || RSP_ERR_O !== 1'b0 || RSP_DAT_O !== 32'h5A5A_0F0F) begin
            mismatched++; $display("FAIL race_ack_wins: vld=%b err=%b dat=%h want 1 0 5a5a0f0f", RSP_VALID_O, RSP_ERR_O, RSP_DAT_O); end
        man_sel  = 1'b0;
        slave_en = 1'b1;
        repeat (3) step();
    endtask
`else
    task automatic test_wait_no_timeout();
        int sc, rc, ri; logic [31:0] rd, ds; logic re, ws; logic [15:0] as;
        slave_en = 1'b0;
        run_cmd(1'b0, 16'h0003, 32'h0, 40, sc, rc, ri, rd, re, as, ws, ds);
        compared++; if (sc !== 40 || rc !== 0) begin mismatched++; $display("FAIL wait_forever: stb=%0d rsp=%0d want 40 0", sc, rc); end
        man_sel = 1'b1;
        man_dat = 32'hCAFE_F00D;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        compared++; if (RSP_VALID_O !== 1'b1 || RSP_DAT_O !== 32'hCAFE_F00D || RSP_ERR_O !== 1'b0) begin
            mismatched++; $display("FAIL late_ack: vld=%b dat=%h err=%b want 1 cafef00d 0", RSP_VALID_O, RSP_DAT_O, RSP_ERR_O); end
        man_sel  = 1'b0;
        slave_en = 1'b1;
        repeat (3) step();
        compared++; if (CMD_READY_O !== 1'b1) begin mismatched++; $display("FAIL ready_after_late_ack: got %b want 1", CMD_READY_O); end
    endtask
`endif

    task automatic test_reset_mid_wait();
        int n = 0, pulses = 0;
        int sc, rc, ri; logic [31:0] rd, ds; logic re, ws; logic [15:0] as;
        slave_en = 1'b0;
        CMD_VALID_I = 1'b1; CMD_WE_I = 1'b0; CMD_ADR_I = 16'h400A;
        while (!CMD_READY_O && n < 50) begin step(); n++; end
        step();
        CMD_VALID_I = 1'b0;
        compared++; if (STB_O !== 1'b1 || BUSY_O !== 1'b1) begin mismatched++; $display("FAIL mid_wait_entry: stb=%b busy=%b want 1 1", STB_O, BUSY_O); end
        RST_I = 1'b0;
        step();
        compared++; if (CYC_O !== 1'b0 || STB_O !== 1'b0 || RSP_VALID_O !== 1'b0) begin
            mismatched++; $display("FAIL mid_wait_reset: cyc=%b stb=%b rsp=%b want 0 0 0", CYC_O, STB_O, RSP_VALID_O); end
        RST_I = 1'b1;
        slave_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (RSP_VALID_O) pulses++;
        end
        compared++; if (pulses !== 0 || CMD_READY_O !== 1'b1) begin mismatched++; $display("FAIL post_reset: pulses=%0d ready=%b want 0 1", pulses, CMD_READY_O); end
        run_cmd(1'b0, 16'h400A, 32'h0, 8, sc, rc, ri, rd, re, as, ws, ds);
        compared++; if (rc !== 1 || rd !== 32'h0000ABCD || re !== 1'b0) begin mismatched++; $display("FAIL post_reset_read: count=%0d dat=%h err=%b want 1 0000abcd 0", rc, rd, re); end
    endtask

    initial begin
        #1;
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
`ifdef WBM_TIMEOUT_EN
        test_timeout();
        test_timeout_ack_race();
`else
        test_wait_no_timeout();
`endif
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_master_sequencer.md
Name: wb_master_sequencer

Overview:
Single-outstanding Wishbone classic master that turns simple command/response transactions from the DSP controller core into Wishbone read/write cycles toward the slave memory/register block. It owns the CYC/STB/WE/ADR/DAT signalling and the mandatory STB-low gap between cycles that the slave needs to re-arm its ACK. It returns read data or a write completion as a one-cycle response pulse, with an optional bus-timeout error path.

Parameters:
ADDR_W, 16, Wishbone address width
DATA_W, 32, Wishbone data width
GAP_CYCLES, 1, minimum cycles CYC_O/STB_O held low between consecutive bus cycles (legal range 1..15)
TIMEOUT_CYCLES, 255, ACK wait limit in cycles; only used with WBM_TIMEOUT_EN (legal range 2..65535)

Ports:
CLK_I  in  1  system clock, all logic on rising edge
RST_I  in  1  synchronous reset, active-low
CMD_VALID_I  in  1  command present
CMD_READY_O  out  1  master can accept a command this cycle
CMD_WE_I  in  1  1 = write, 0 = read
CMD_ADR_I  in  ADDR_W  target address
CMD_DAT_I  in  DATA_W  write data
RSP_VALID_O  out  1  one-cycle response pulse
RSP_DAT_O  out  DATA_W  read data (0 for writes and errors)
RSP_ERR_O  out  1  timeout error flag, valid with RSP_VALID_O
BUSY_O  out  1  high in any state other than IDLE
CYC_O  out  1  Wishbone cycle
STB_O  out  1  Wishbone strobe
WE_O  out  1  Wishbone write enable
ADR_O  out  ADDR_W  Wishbone address
DAT_O  out  DATA_W  Wishbone write data
DAT_I  in  DATA_W  Wishbone read data
ACK_I  in  1  Wishbone acknowledge

Behaviour:
- Clock is CLK_I; reset is RST_I, synchronous, active-low. While RST_I=0 at a rising edge: state=IDLE, CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0, RSP_VALID_O=0, RSP_DAT_O=0, RSP_ERR_O=0, gap and timeout counters=0. CMD_READY_O is 0 during reset and 1 in IDLE afterwards.
- All outputs registered except CMD_READY_O and BUSY_O, which are decoded from the state register.
- States: IDLE, WAIT, GAP.
- IDLE: CMD_READY_O=1. Handshake on CMD_VALID_I & CMD_READY_O at an edge: latch WE/ADR/DAT onto WE_O/ADR_O/DAT_O, set CYC_O=STB_O=1, clear timeout counter, go to WAIT.
- WAIT: CYC_O/STB_O/WE_O/ADR_O/DAT_O held stable. ACK_I sampled each edge; ACK_I is ignored in every other state.
  - ACK_I=1: CYC_O=STB_O=0, WE_O=0. For reads, RSP_DAT_O<=DAT_I; for writes, RSP_DAT_O<=0. RSP_ERR_O<=0, RSP_VALID_O<=1. Load gap counter with GAP_CYCLES, go to GAP.
- GAP: CYC_O=STB_O=0, CMD_READY_O=0. The counter decrements each cycle; on reaching 0, go to IDLE. This guarantees STB_O is low for at least GAP_CYCLES full cycles before the next STB_O rise.
- RSP_VALID_O is high for exactly one cycle per command. There is no backpressure on the response. RSP_DAT_O and RSP_ERR_O hold their values until the next response.
- Latency with a slave that registers ACK one cycle after seeing STB: handshake at edge N, STB_O high after N, ACK_I sampled high at N+2, RSP_VALID_O high in the cycle after N+2. Back-to-back command throughput is 3+GAP_CYCLES cycles per command.
- A command is never accepted outside IDLE. CMD_VALID_I may stay high and is accepted on the first IDLE cycle.
- Reset mid-cycle (WAIT or GAP) aborts immediately to the reset values above, with no response pulse.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- With the macro: in WAIT, a 16-bit counter increments each cycle without ACK_I. When the count reaches TIMEOUT_CYCLES-1 with ACK_I still 0, the master drops CYC_O/STB_O, pulses RSP_VALID_O with RSP_ERR_O=1 and RSP_DAT_O=0, then enters GAP.
- ACK_I=1 on the same edge as expiry takes priority and produces a normal response.
- Without the macro: no counter logic, RSP_ERR_O is tied 0, and WAIT persists indefinitely until ACK_I.

Test Plan:
- Read ADR 0x400A against a slave model that returns 0xABCD -> CYC_O/STB_O high 2 cycles, RSP_VALID_O single pulse, RSP_DAT_O=0x0000ABCD, RSP_ERR_O=0.
- Write ADR 0x0002 DAT 0x12345678, then read ADR 0x0002 -> write response RSP_DAT_O=0, read response RSP_DAT_O=0x12345678.
- 4 back-to-back reads with CMD_VALID_I held high, GAP_CYCLES=1 -> STB_O low at least 1 cycle between cycles, exactly 4 RSP_VALID_O pulses spaced 4 cycles apart, CMD_READY_O=0 whenever BUSY_O=1.
- WBM_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ACK_I tied 0 -> STB_O high 16 cycles then low, RSP_ERR_O=1, RSP_DAT_O=0, next command accepted after the gap.
- Same edge ACK_I=1 and timeout expiry -> RSP_ERR_O=0, RSP_DAT_O=DAT_I.
- Assert RST_I=0 for 1 cycle during WAIT -> CYC_O=STB_O=0 next cycle, no RSP_VALID_O, CMD_READY_O=1 after reset release, a subsequent read completes normally.
